// File: rtl/vec_exec_unit.sv
// vec_exec_unit: multi-beat 16-lane vector/scalar ALU with NZCV flags; opcode 111 multiplies only when VEU_MUL_EN is defined
module vec_exec_unit #(
  parameter int LANES_PER_BEAT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ValidE,
  input  logic             FlushE,
  input  logic             v_s_e,
  input  logic [2:0]       ALUControlE,
  input  logic             ALUSrcE,
  input  logic [15:0][31:0] RD1E,
  input  logic [15:0][31:0] RD2E,
  input  logic [31:0]      ExtImmE,
  output logic [15:0][31:0] ALUResultE,
  output logic [3:0]       ALUFlags,
  output logic             DoneE,
  output logic             StallE
);
  localparam int BEATS = 16 / LANES_PER_BEAT;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [3:0] cnt;
  logic vs_q;
  logic [2:0] op_q;
  logic [15:0][31:0] a_q, b_q;
  logic [LANES_PER_BEAT-1:0][31:0] r;
  logic accept, last, c, v;
  logic [31:0] res0;
  logic [32:0] sum;

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000: return a + b;
      3'b001: return a - b;
      3'b010: return a & b;
      3'b011: return a | b;
      3'b100: return a ^ b;
      3'b101: return a << b[4:0];
      3'b110: return a >> b[4:0];
`ifdef VEU_MUL_EN
      default: return a * b;
`else
      default: return '0;
`endif
    endcase
  endfunction

  assign accept = state == IDLE && ValidE && !FlushE;
  assign last = !vs_q || cnt == 4'(BEATS - 1);
  assign StallE = state != IDLE;
  // lane 0 is produced on beat 0; later beats reuse the registered copy for flags
  assign res0 = cnt == 4'd0 ? r[0] : ALUResultE[0];
  assign sum = op_q[0] ? {1'b0, a_q[0]} - {1'b0, b_q[0]} : {1'b0, a_q[0]} + {1'b0, b_q[0]};
  assign c = op_q == 3'b000 ? sum[32] : op_q == 3'b001 ? !sum[32] : 1'b0;
  assign v = op_q[2:1] == 2'b00 && ((a_q[0][31] ^ b_q[0][31]) == op_q[0]) && sum[31] != a_q[0][31];

  // next-state: flush always returns to IDLE and beats RUN/DONE
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = accept ? RUN : IDLE;
      RUN:     state_d = FlushE ? IDLE : last ? DONE : RUN;
      default: state_d = IDLE;
    endcase
  end

  // lanes computed this beat
  always_comb begin
    for (int l = 0; l < LANES_PER_BEAT; l++)
      r[l] = alu(op_q, a_q[4'(int'(cnt) * LANES_PER_BEAT + l)], b_q[4'(int'(cnt) * LANES_PER_BEAT + l)]);
  end

  // state, beat counter and operand capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      vs_q <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        cnt <= '0;
        vs_q <= v_s_e;
        op_q <= ALUControlE;
        a_q <= RD1E;
        b_q <= ALUSrcE ? {16{ExtImmE}} : RD2E;
      end else if (state == RUN && !last)
        cnt <= cnt + 4'd1;
    end
  end

  // result lanes, flags on entry to DONE, and the done pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ALUResultE <= '0;
      ALUFlags <= '0;
      DoneE <= 1'b0;
    end else begin
      DoneE <= state == DONE && !FlushE;
      if (state == RUN && !FlushE) begin
        if (!vs_q)
          ALUResultE <= {480'b0, r[0]};
        else
          for (int l = 0; l < LANES_PER_BEAT; l++)
            ALUResultE[4'(int'(cnt) * LANES_PER_BEAT + l)] <= r[l];
        if (last)
          ALUFlags <= {res0[31], res0 == 32'd0, c, v};
      end
    end
  end
endmodule
